ddr2_controller_example_if0_dmaster_b2p_decoder: RTL

Byte-stream-to-packet decoder for the debug master path. It consumes the escaped byte stream produced by the packets-to-bytes side and strips the in-band control codes. It regenerates startofpacket, endofpacket and channel on an Avalon-ST packet interface toward the debug master. It is the inverse of the p2b encoder/channel adapter chain and sits between the JTAG byte source and the master's packet input.

---
 rtl/ddr2_controller_example_if0_dmaster_b2p_decoder.sv | 82 ++++++++
 1 files changed

// File: rtl/ddr2_controller_example_if0_dmaster_b2p_decoder.sv
// ddr2_controller_example_if0_dmaster_b2p_decoder: escaped byte stream to Avalon-ST packets (optional DMASTER_B2P_PKT_COUNT_EN adds pkt_count)
module ddr2_controller_example_if0_dmaster_b2p_decoder #(
  parameter int CHANNEL_WIDTH = 8,
  parameter logic [7:0] SOP_CODE = 8'h7A,
  parameter logic [7:0] EOP_CODE = 8'h7B,
  parameter logic [7:0] CHAN_CODE = 8'h7C,
  parameter logic [7:0] ESC_CODE = 8'h7D
) (
  input logic clk,
  input logic reset_n,
  output logic in_ready,
  input logic in_valid,
  input logic [7:0] in_data,
  input logic out_ready,
  output logic out_valid,
  output logic [7:0] out_data,
  output logic out_startofpacket,
  output logic out_endofpacket,
`ifdef DMASTER_B2P_PKT_COUNT_EN
  output logic [15:0] pkt_count,
`endif
  output logic [CHANNEL_WIDTH-1:0] out_channel
);
  logic sop_pend, eop_pend, chan_pend, esc_pend;
  logic [CHANNEL_WIDTH-1:0] cur_chan;
  logic accept, is_esc, is_sop, is_eop, is_chan, is_lit, emit, set_chan;
  logic [7:0] lit;
  assign in_ready = !out_valid || out_ready;
  // classify the incoming byte; an escaped byte is always a literal
  always_comb begin
    accept = in_valid && in_ready;
    is_esc = !esc_pend && in_data == ESC_CODE;
    is_sop = !esc_pend && in_data == SOP_CODE;
    is_eop = !esc_pend && in_data == EOP_CODE;
    is_chan = !esc_pend && in_data == CHAN_CODE;
    is_lit = !(is_esc || is_sop || is_eop || is_chan);
    lit = esc_pend ? in_data ^ 8'h20 : in_data;
    emit = accept && is_lit && !chan_pend;
    set_chan = accept && is_lit && chan_pend;
  end
  // pending control flags and the sticky current channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
      chan_pend <= 1'b0;
      esc_pend <= 1'b0;
      cur_chan <= '0;
    end else if (accept) begin
      esc_pend <= is_esc;
      sop_pend <= is_sop ? 1'b1 : emit ? 1'b0 : sop_pend;
      eop_pend <= is_eop ? 1'b1 : emit ? 1'b0 : eop_pend;
      chan_pend <= is_chan ? 1'b1 : set_chan ? 1'b0 : chan_pend;
      if (set_chan) cur_chan <= CHANNEL_WIDTH'(lit);
    end
  end
  // output beat register, held while the sink stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket <= 1'b0;
      out_channel <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data <= lit;
      out_startofpacket <= sop_pend;
      out_endofpacket <= eop_pend;
      out_channel <= cur_chan;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef DMASTER_B2P_PKT_COUNT_EN
  // count packets completed toward the master, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pkt_count <= '0;
    else if (out_valid && out_ready && out_endofpacket) pkt_count <= pkt_count + 16'd1;
  end
`endif
endmodule
